// File: rtl/pll_reset_sequencer.sv
// Synchronizes the PLL lock flag, qualifies it and drives the core reset; counts lock losses.
// Define PLL_RESET_SEQ_TIMEOUT_EN to add the sticky WAIT_LOCK timeout flag (lock_timeout).
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int FILTER_CYCLES  = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 locked,
  output logic                 reset_out,
  output logic                 ready,
  output logic [CNT_WIDTH-1:0] loss_count,
  output logic                 lock_timeout
);

  // state      | meaning
  // RESET_HOLD | fixed-length reset hold, lock ignored
  // WAIT_LOCK  | waiting for synchronized lock
  // STABLE     | counting consecutive locked cycles before release
  // RUN        | core out of reset, filtering lock drops
  typedef enum logic [1:0] {RESET_HOLD, WAIT_LOCK, STABLE, RUN} state_t;

  localparam int MAX_HS = (HOLD_CYCLES > STABLE_CYCLES) ? HOLD_CYCLES : STABLE_CYCLES;
  localparam int MAX_HSF = (MAX_HS > FILTER_CYCLES) ? MAX_HS : FILTER_CYCLES;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  localparam int MAX_ALL = (MAX_HSF > TIMEOUT_CYCLES) ? MAX_HSF : TIMEOUT_CYCLES;
`else
  localparam int MAX_ALL = MAX_HSF;
`endif
  localparam int CW = $clog2(MAX_ALL) + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 || STABLE_CYCLES < 1 ||
      FILTER_CYCLES < 1 || CNT_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("pll_reset_sequencer: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= RESET_HOLD;
      cnt        <= '0;
      reset_out  <= 1'b1;
      ready      <= 1'b0;
      loss_count <= '0;
    end else begin
      case (state)
        RESET_HOLD: begin
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
          // parks at TIMEOUT_CYCLES-1 once the flag is set so it never wraps
          else if (cnt != CW'(TIMEOUT_CYCLES - 1)) begin
            cnt <= cnt + CW'(1);
          end
`endif
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            state     <= RUN;
            cnt       <= '0;
            reset_out <= 1'b0;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (locked_s) begin
            cnt <= '0;
          end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
            state     <= RESET_HOLD;
            cnt       <= '0;
            reset_out <= 1'b1;
            ready     <= 1'b0;
            if (loss_count != '1) begin
              loss_count <= loss_count + CNT_WIDTH'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= RESET_HOLD;
          cnt       <= '0;
          reset_out <= 1'b1;
          ready     <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_RESET_SEQ_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_timeout <= 1'b0;
    end else if (state == WAIT_LOCK && !locked_s && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      lock_timeout <= 1'b1;
    end
  end
`else
  assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: phase-level reference model plus directed latency checks.
module tb_pll_reset_sequencer;
  localparam int S    = 2;
  localparam int HOLD = 4;
  localparam int STAB = 8;
  localparam int FILT = 3;
  localparam int CW   = 2;
  localparam int TO   = 20;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          locked = 1'b0;
  logic          reset_out;
  logic          ready;
  logic          lock_timeout;
  logic [CW-1:0] loss_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  pll_reset_sequencer #(
    .SYNC_STAGES(S), .HOLD_CYCLES(HOLD), .STABLE_CYCLES(STAB),
    .FILTER_CYCLES(FILT), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clk), .reset(rst), .locked(locked), .reset_out(reset_out),
    .ready(ready), .loss_count(loss_count), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = holding, 1 = qualifying lock, 2 = core running.
  // The lock flag seen by the controller at an edge is the one sampled S edges earlier.
  logic [S-1:0] hist;
  logic         ls_m;
  int           phase, hold_n, high_run, low_run, wait_len, m_loss;
  bit           m_to;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist = '0; phase = 0; hold_n = 0; high_run = 0; low_run = 0;
      wait_len = 0; m_loss = 0; m_to = 1'b0;
    end else begin
      ls_m = hist[S-1];
      hist = {hist[S-2:0], locked};
      if (phase == 0) begin
        hold_n++;
        if (hold_n == HOLD) begin
          phase = 1; high_run = 0; wait_len = 0;
        end
      end else if (phase == 1) begin
        if (ls_m) begin
          high_run++;
          wait_len = 0;
        end else begin
          wait_len = (high_run == 0) ? wait_len + 1 : 0;
          high_run = 0;
        end
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
        if (wait_len >= TO) m_to = 1'b1;
`endif
        // first high edge leaves the wait, then STAB more qualify the lock
        if (high_run == STAB + 1) begin
          phase = 2; low_run = 0;
        end
      end else begin
        low_run = ls_m ? 0 : low_run + 1;
        if (low_run == FILT) begin
          phase = 0; hold_n = 0;
          if (m_loss < (1 << CW) - 1) m_loss++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_reset_out", 32'(reset_out), 32'(phase != 2));
      check("cyc_ready", 32'(ready), 32'(phase == 2));
      check("cyc_loss_count", 32'(loss_count), 32'(m_loss));
      check("cyc_lock_timeout", 32'(lock_timeout), 32'(m_to));
    end
  end

  function automatic logic sig(input int sel);
    return (sel == 0) ? reset_out : lock_timeout;
  endfunction

  // Counts negedges until the selected output reaches val; n-th negedge follows the n-th posedge.
  task automatic wait_sig(input int sel, input logic val, input int max, input string name,
                          output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(sel) !== val && n < max);
    if (sig(sel) !== val) begin
      checks++;
      failures++;
      $display("FAIL %s: signal still %b after %0d cycles, wanted %b", name, sig(sel), n, val);
    end
  endtask

  task automatic reset_mid(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check({name, "_reset_out"}, 32'(reset_out), 1);
    check({name, "_ready"}, 32'(ready), 0);
    check({name, "_loss"}, 32'(loss_count), 0);
    check({name, "_timeout"}, 32'(lock_timeout), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    int rises;
    int exp_loss [5];
    exp_loss = '{1, 2, 3, 3, 3};

    // reset state
    rst = 1'b1; locked = 1'b1;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_reset_out", 32'(reset_out), 1);
    check("rst_ready", 32'(ready), 0);
    check("rst_loss", 32'(loss_count), 0);
    check("rst_timeout", 32'(lock_timeout), 0);

    // 1: locked high throughout: hold 4, one wait edge, 8 stable edges -> falls on edge 13
    rst = 1'b0;
    wait_sig(0, 1'b0, 40, "t1_release", n);
    check("t1_release_edges", n, 13);
    check("t1_ready", 32'(ready), 1);
    check("t1_loss", 32'(loss_count), 0);

    // 2: two-cycle glitch in RUN is filtered
    locked = 1'b0;
    repeat (2) @(negedge clk);
    locked = 1'b1;
    rises = 0;
    repeat (10) begin
      @(negedge clk);
      if (reset_out !== 1'b0) rises++;
    end
    check("t2_glitch_rises", rises, 0);
    check("t2_loss", 32'(loss_count), 0);

    // 3: real loss rises at L0+S+FILT-1 (5th negedge), then full re-release 13 edges later
    locked = 1'b0;
    wait_sig(0, 1'b1, 20, "t3_loss", n);
    check("t3_loss_edges", n, 5);
    check("t3_loss_count", 32'(loss_count), 1);
    locked = 1'b1;
    wait_sig(0, 1'b0, 40, "t3_rerelease", n);
    check("t3_rerelease_edges", n, 13);

    // 4: one-cycle drop at stable count 5 restarts the window: release at 20 instead of 13
    locked = 1'b0;
    wait_sig(0, 1'b1, 20, "t4_loss", n);
    locked = 1'b1;
    repeat (8) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    wait_sig(0, 1'b0, 40, "t4_release", n);
    check("t4_release_edges", n + 9, 20);
    check("t4_loss_count", 32'(loss_count), 2);

    // 5: async reset mid-RUN, then saturation over five losses, then reset mid-RUN again
    reset_mid("t5a");
    rst = 1'b0;
    wait_sig(0, 1'b0, 40, "t5_release", n);
    check("t5_release_edges", n, 13);
    for (int i = 0; i < 5; i++) begin
      locked = 1'b0;
      wait_sig(0, 1'b1, 20, "t5_loss", n);
      check("t5_loss_edges", n, 5);
      check("t5_loss_count", 32'(loss_count), exp_loss[i]);
      locked = 1'b1;
      wait_sig(0, 1'b0, 40, "t5_rerelease", n);
      check("t5_rerelease_edges", n, 13);
    end
    reset_mid("t5b");

    // 6: lock absent after reset; timeout (if built) 20 edges after entering WAIT_LOCK
    locked = 1'b0;
    rst = 1'b0;
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    wait_sig(1, 1'b1, 60, "t6_timeout", n);
    check("t6_timeout_edges", n, HOLD + TO);
`else
    repeat (HOLD + TO) @(negedge clk);
    check("t6_timeout_off", 32'(lock_timeout), 0);
`endif
    // release latency from first high sample E0 while waiting: E0 + S + STAB
    locked = 1'b1;
    wait_sig(0, 1'b0, 40, "t6_release", n);
    check("t6_release_edges", n, 1 + S + STAB);
`ifdef PLL_RESET_SEQ_TIMEOUT_EN
    check("t6_timeout_sticky", 32'(lock_timeout), 1);
`else
    check("t6_timeout_still_off", 32'(lock_timeout), 0);
`endif
    check("t6_ready", 32'(ready), 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
